// File: rtl/mem_lsu_pkg.sv
// Shared opcode, byte-enable and state definitions
// for the memory-access stage.
package mem_lsu_pkg;

  localparam int ALUOP_W = 8;

  localparam logic [ALUOP_W-1:0] ALU_OP_NOP  = 8'b00000000;
  localparam logic [ALUOP_W-1:0] ALU_OP_ADDU = 8'b00100001;
  localparam logic [ALUOP_W-1:0] ALU_OP_LB   = 8'b11100000;
  localparam logic [ALUOP_W-1:0] ALU_OP_LH   = 8'b11100001;
  localparam logic [ALUOP_W-1:0] ALU_OP_LW   = 8'b11100011;
  localparam logic [ALUOP_W-1:0] ALU_OP_SB   = 8'b11101000;
  localparam logic [ALUOP_W-1:0] ALU_OP_SH   = 8'b11101001;
  localparam logic [ALUOP_W-1:0] ALU_OP_SW   = 8'b11101011;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_LO   = 4'b0011;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } lsu_state_t;

  function automatic logic is_load_op(
    input logic [ALUOP_W-1:0] op
  );
    return op inside {ALU_OP_LB, ALU_OP_LH, ALU_OP_LW};
  endfunction

  function automatic logic is_store_op(
    input logic [ALUOP_W-1:0] op
  );
    return op inside {ALU_OP_SB, ALU_OP_SH, ALU_OP_SW};
  endfunction

  function automatic logic is_mem_op(
    input logic [ALUOP_W-1:0] op
  );
    return is_load_op(op) || is_store_op(op);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extraction and
// sign-extension for loads, and misalignment detect.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [ALUOP_W-1:0] st_op,
  input  logic [1:0]         st_lane,
  input  logic [31:0]        st_data,
  output logic [3:0]         st_be,
  output logic [31:0]        st_wdata,
  output logic               misalign,
  input  logic [ALUOP_W-1:0] ld_op,
  input  logic [1:0]         ld_lane,
  input  logic [31:0]        rdata,
  output logic [31:0]        ld_data
);

  logic [15:0] half;
  logic [7:0]  byt;

  always_comb begin
    st_be    = BE_WORD;
    st_wdata = st_data;
    misalign = 1'b0;
    case (st_op)
      ALU_OP_LW, ALU_OP_SW: misalign = |st_lane;
      ALU_OP_LH: misalign = st_lane[0];
      ALU_OP_SH: begin
        misalign = st_lane[0];
        st_be    = st_lane[1] ? BE_HI : BE_LO;
        st_wdata = {2{st_data[15:0]}};
      end
      ALU_OP_SB: begin
        st_be    = 4'b0001 << st_lane;
        st_wdata = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    half = ld_lane[1] ? rdata[31:16] : rdata[15:0];
    byt  = rdata[7:0];
    case (ld_lane)
      2'd1:    byt = rdata[15:8];
      2'd2:    byt = rdata[23:16];
      2'd3:    byt = rdata[31:24];
      default: byt = rdata[7:0];
    endcase
  end

  always_comb begin
    ld_data = rdata;
    case (ld_op)
      ALU_OP_LH: ld_data = {{16{half[15]}}, half};
      ALU_OP_LB: ld_data = {{24{byt[7]}}, byt};
      default:   ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: pass-through for ALU results,
// req/ack SRAM access with upstream stall for loads/stores.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [4:0]         wd_i,
  input  logic               wreg_i,
  input  logic [31:0]        wdata_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        reg2_i,
  output logic               stallreq_o,
  output logic               dreq_o,
  output logic               dwe_o,
  output logic [3:0]         dbe_o,
  output logic [31:0]        daddr_o,
  output logic [31:0]        dwdata_o,
  input  logic               dack_i,
  input  logic [31:0]        drdata_i,
  output logic               valid_o,
  output logic [4:0]         wd_o,
  output logic               wreg_o,
  output logic [31:0]        wdata_o,
  output logic               addr_err_o
);

  lsu_state_t state, state_nx;

  logic [ALUOP_W-1:0] op_q;
  logic [1:0]         lane_q;
  logic [4:0]         wd_q;
  logic               wreg_q;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        misalign;

  logic accept, is_mem;
  logic pass, err, issue, done;

  assign is_mem = is_mem_op(aluop_i);
  assign accept = (state == IDLE) && valid_i;
  assign pass   = accept && !is_mem;
  assign err    = accept && is_mem && misalign;
  assign issue  = accept && is_mem && !misalign;
  assign done   = (state == REQ) && dack_i;

  lsu_align u_align (
    .st_op    (aluop_i),
    .st_lane  (mem_addr_i[1:0]),
    .st_data  (reg2_i),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .misalign (misalign),
    .ld_op    (op_q),
    .ld_lane  (lane_q),
    .rdata    (drdata_i),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (issue) state_nx = REQ;
      REQ:     if (dack_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = (state == REQ);
    dreq_o     = (state == REQ);
  end

  // SRAM-side fields only load on issue, so they stay stable across REQ
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= ALU_OP_NOP;
      lane_q   <= 2'd0;
      wd_q     <= 5'd0;
      wreg_q   <= 1'b0;
      dwe_o    <= 1'b0;
      dbe_o    <= 4'd0;
      daddr_o  <= ZeroWord;
      dwdata_o <= ZeroWord;
    end else if (issue) begin
      op_q     <= aluop_i;
      lane_q   <= mem_addr_i[1:0];
      wd_q     <= wd_i;
      wreg_q   <= wreg_i;
      dwe_o    <= is_store_op(aluop_i);
      dbe_o    <= st_be;
      daddr_o  <= {mem_addr_i[31:2], 2'b00};
      dwdata_o <= st_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o    <= 1'b0;
      wd_o       <= 5'd0;
      wreg_o     <= 1'b0;
      wdata_o    <= ZeroWord;
      addr_err_o <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      wreg_o     <= 1'b0;
      addr_err_o <= 1'b0;
      unique case (1'b1)
        pass: begin
          valid_o <= 1'b1;
          wd_o    <= wd_i;
          wreg_o  <= wreg_i;
          wdata_o <= wdata_i;
        end
        err: begin
          valid_o    <= 1'b1;
          wd_o       <= wd_i;
          addr_err_o <= 1'b1;
          wdata_o    <= ZeroWord;
        end
        done: begin
          valid_o <= 1'b1;
          wd_o    <= wd_q;
          wreg_o  <= is_load_op(op_q) && wreg_q;
          wdata_o <= is_load_op(op_q) ? ld_data : ZeroWord;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a size/offset
// arithmetic model of the load/store rules.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_i;
  logic [ALUOP_W-1:0] aluop_i;
  logic [4:0]         wd_i;
  logic               wreg_i;
  logic [31:0]        wdata_i;
  logic [31:0]        mem_addr_i;
  logic [31:0]        reg2_i;
  logic               stallreq_o;
  logic               dreq_o;
  logic               dwe_o;
  logic [3:0]         dbe_o;
  logic [31:0]        daddr_o;
  logic [31:0]        dwdata_o;
  logic               dack_i;
  logic [31:0]        drdata_i;
  logic               valid_o;
  logic [4:0]         wd_o;
  logic               wreg_o;
  logic [31:0]        wdata_o;
  logic               addr_err_o;

  int checks = 0;
  int errors = 0;

  mem_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .aluop_i    (aluop_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .mem_addr_i (mem_addr_i),
    .reg2_i     (reg2_i),
    .stallreq_o (stallreq_o),
    .dreq_o     (dreq_o),
    .dwe_o      (dwe_o),
    .dbe_o      (dbe_o),
    .daddr_o    (daddr_o),
    .dwdata_o   (dwdata_o),
    .dack_i     (dack_i),
    .drdata_i   (drdata_i),
    .valid_o    (valid_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .addr_err_o (addr_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [7:0] op);
    if (op == ALU_OP_LW || op == ALU_OP_SW) return 4;
    if (op == ALU_OP_LH || op == ALU_OP_SH) return 2;
    if (op == ALU_OP_LB || op == ALU_OP_SB) return 1;
    return 0;
  endfunction

  task automatic issue(input logic [7:0]  op,
                       input logic [31:0] addr,
                       input logic [31:0] alu,
                       input logic [31:0] r2,
                       input logic [4:0]  wd,
                       input logic        wr,
                       input int          waits,
                       input logic [31:0] rd);
    int sz, lane, stalls;
    logic ld, mis;
    logic [31:0] e_be, e_sd, e_ld, sh, mask;
    sz   = op_size(op);
    lane = int'(addr % 4);
    ld   = (op == ALU_OP_LW || op == ALU_OP_LH || op == ALU_OP_LB);
    mis  = (sz != 0) && (lane % sz != 0);
    e_be = ld ? 32'hF : ((32'(1) << sz) - 1) << lane;
    if (sz == 1)      e_sd = {24'd0, r2[7:0]} * 32'h0101_0101;
    else if (sz == 2) e_sd = {16'd0, r2[15:0]} * 32'h0001_0001;
    else              e_sd = r2;
    sh   = rd >> (8 * lane);
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'(1) << (8 * sz)) - 1;
    e_ld = sh & mask;
    if (sz == 1 && e_ld[7])  e_ld = e_ld | 32'hFFFF_FF00;
    if (sz == 2 && e_ld[15]) e_ld = e_ld | 32'hFFFF_0000;

    @(negedge clk);
    chk("idle_valid", 32'(valid_o), 0);
    chk("idle_stall", 32'(stallreq_o), 0);
    valid_i    = 1'b1;
    aluop_i    = op;
    mem_addr_i = addr;
    wdata_i    = alu;
    reg2_i     = r2;
    wd_i       = wd;
    wreg_i     = wr;
    @(negedge clk);
    valid_i = 1'b0;
    if (sz == 0 || mis) begin
      chk("imm_valid", 32'(valid_o), 1);
      chk("imm_err", 32'(addr_err_o), 32'(mis));
      chk("imm_wreg", 32'(wreg_o), mis ? 0 : 32'(wr));
      chk("imm_wdata", wdata_o, mis ? 0 : alu);
      chk("imm_dreq", 32'(dreq_o), 0);
      chk("imm_stall", 32'(stallreq_o), 0);
      if (!mis) chk("imm_wd", 32'(wd_o), 32'(wd));
    end else begin
      stalls = 0;
      chk("req_dreq", 32'(dreq_o), 1);
      chk("req_addr", daddr_o, addr & 32'hFFFF_FFFC);
      chk("req_dwe", 32'(dwe_o), ld ? 0 : 1);
      chk("req_dbe", 32'(dbe_o), e_be);
      if (!ld) chk("req_dwdata", dwdata_o, e_sd);
      for (int i = 0; i < waits; i++) begin
        stalls += 32'(stallreq_o);
        chk("wait_valid", 32'(valid_o), 0);
        chk("wait_dreq", 32'(dreq_o), 1);
        chk("wait_addr", daddr_o, addr & 32'hFFFF_FFFC);
        valid_i = 1'b1;
        aluop_i = ALU_OP_ADDU;
        wdata_i = $urandom;
        @(negedge clk);
      end
      valid_i  = 1'b0;
      stalls  += 32'(stallreq_o);
      dack_i   = 1'b1;
      drdata_i = rd;
      @(negedge clk);
      dack_i   = 1'b0;
      drdata_i = $urandom;
      chk("stall_cycles", 32'(stalls), 32'(waits + 1));
      chk("done_valid", 32'(valid_o), 1);
      chk("done_wd", 32'(wd_o), 32'(wd));
      chk("done_wreg", 32'(wreg_o), ld ? 32'(wr) : 0);
      chk("done_wdata", wdata_o, ld ? e_ld : 0);
      chk("done_err", 32'(addr_err_o), 0);
      chk("done_dreq", 32'(dreq_o), 0);
      chk("done_stall", 32'(stallreq_o), 0);
    end
  endtask

  logic [7:0] ops [7];

  initial begin
    ops = '{ALU_OP_ADDU, ALU_OP_LW, ALU_OP_LH, ALU_OP_LB,
            ALU_OP_SW, ALU_OP_SH, ALU_OP_SB};
    rst = 1'b1; valid_i = 1'b0; aluop_i = ALU_OP_NOP;
    wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    mem_addr_i = '0; reg2_i = '0; dack_i = 1'b0; drdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_dreq", 32'(dreq_o), 0);
    chk("rst_stall", 32'(stallreq_o), 0);
    chk("rst_dbe", 32'(dbe_o), 0);
    chk("rst_wdata", wdata_o, 0);
    rst = 1'b0;

    issue(ALU_OP_ADDU, 32'h0, 32'h1234_5678, 32'h0, 5'd3, 1'b1, 0, 32'h0);
    issue(ALU_OP_LB, 32'h1003, 32'h0, 32'h0, 5'd4, 1'b1, 3, 32'h80FF_FFFF);
    issue(ALU_OP_SH, 32'h2002, 32'h0, 32'hAAAA_1234, 5'd5, 1'b1, 1, 32'h0);
    issue(ALU_OP_LW, 32'h3001, 32'h0, 32'h0, 5'd6, 1'b1, 0, 32'h0);
    issue(ALU_OP_LH, 32'h4000, 32'h0, 32'h0, 5'd7, 1'b1, 0, 32'h0000_7FFF);

    // reset abandons an outstanding store
    @(negedge clk);
    valid_i = 1'b1; aluop_i = ALU_OP_SW;
    mem_addr_i = 32'h5000; reg2_i = 32'hDEAD_BEEF;
    @(negedge clk);
    valid_i = 1'b0;
    chk("rq_dreq1", 32'(dreq_o), 1);
    @(negedge clk);
    chk("rq_dreq2", 32'(dreq_o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rq_dreq", 32'(dreq_o), 0);
    chk("rq_stall", 32'(stallreq_o), 0);
    chk("rq_valid", 32'(valid_o), 0);
    dack_i = 1'b1;
    @(negedge clk);
    dack_i = 1'b0;
    chk("late_ack_valid", 32'(valid_o), 0);
    chk("late_ack_dreq", 32'(dreq_o), 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        dack_i = 1'b1;
        @(negedge clk);
        dack_i = 1'b0;
        chk("idle_ack_valid", 32'(valid_o), 0);
        chk("idle_ack_dreq", 32'(dreq_o), 0);
      end
      issue(ops[$urandom_range(0, 6)], $urandom, $urandom, $urandom,
            5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage placed directly after the execute stage. It consumes the execute result (destination register, write enable, ALU data, ALU opcode, effective address, store data) and drives the data SRAM through a variable-latency req/ack handshake. It produces the value for writeback, with load data lane-extracted and sign-extended. Non-memory instructions pass through with one cycle of latency. Memory instructions stall the upstream pipeline until the SRAM acknowledges.

## Interface
- ALUOP_W, 8, width of the ALU opcode bus (same encoding as the execute stage)
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- valid_i  in  1  upstream presents an instruction this cycle
- aluop_i  in  ALUOP_W  opcode; memory ops are ALU_OP_LW/LH/LB/SW/SH/SB
- wd_i  in  5  destination register number
- wreg_i  in  1  destination write enable
- wdata_i  in  32  ALU result (non-memory ops)
- mem_addr_i  in  32  effective byte address
- reg2_i  in  32  store data
- stallreq_o  out  1  upstream must hold its current instruction
- dreq_o  out  1  SRAM request, held until dack_i
- dwe_o  out  1  1 = store
- dbe_o  out  4  byte enables, bit n = bits 8n+7:8n (little-endian)
- daddr_o  out  32  word address (mem_addr_i with [1:0] forced to 0)
- dwdata_o  out  32  lane-replicated store data
- dack_i  in  1  SRAM completes the request; drdata_i valid on loads
- drdata_i  in  32  SRAM read word
- valid_o, wd_o (5), wreg_o (1), wdata_o (32)  out  writeback result, valid for one cycle
- addr_err_o  out  1  misaligned access, pulses with valid_o

## Operation
- States: IDLE, REQ.
- IDLE, valid_i, non-memory op:
  - Next edge: valid_o=1; wd/wreg/wdata copied from the inputs.
- IDLE, valid_i, aligned memory op:
  - Latch op, lane and store data.
  - Go to REQ; dreq_o=1 from the next cycle.
- REQ:
  - stallreq_o=1; valid_i ignored; SRAM outputs held stable.
  - On dack_i: go to IDLE; next edge valid_o=1.
    - Load: wdata_o = formatted drdata_i, wreg_o = latched wreg_i.
    - Store: wreg_o=0, wdata_o=0.
- Misaligned access (LW with addr[1:0]≠0, LH/SH with addr[0]=1):
  - No SRAM request.
  - Next edge: valid_o=1, addr_err_o=1, wreg_o=0, wdata_o=0.
- Load format:
  - LW: full word.
  - LH: half selected by addr[1], sign-extended.
  - LB: byte selected by addr[1:0], sign-extended.
- Store lanes:
  - SW: dbe_o=1111, data as-is.
  - SH: dbe_o = addr[1] ? 1100 : 0011, dwdata_o = {2{reg2_i[15:0]}}.
  - SB: dbe_o = 0001 << addr[1:0], dwdata_o = {4{reg2_i[7:0]}}.
- Loads drive dwe_o=0 and dbe_o=1111.
- dack_i while in IDLE is ignored.

## Timing
- Reset values: state IDLE; all outputs 0, including stallreq_o, dreq_o, dbe_o, valid_o.
- Non-memory op: accepted at edge n, valid_o at cycle n+1.
- Memory op:
  - Accepted at edge n; dreq_o high from cycle n+1.
  - dack_i sampled at cycle k ≥ n+1; valid_o at cycle k+1; dreq_o low at k+1.
  - Minimum latency 2 cycles.
- stallreq_o is a combinational decode of state==REQ. It is high in cycles n+1..k, and the upstream holds its next instruction throughout.
- dack_i in the first REQ cycle is legal (zero-wait SRAM).
- rst during REQ: at the next edge return to IDLE, dreq_o=0, the access is abandoned, and a late dack_i is ignored.
- rst has priority over every other event.

## Structure
- Shared defines package holds:
  - ALU_OP_* opcode constants and ALUOP_W.
  - ZeroWord.
  - Byte-enable constants BE_WORD/BE_HI/BE_LO.
- Sub-module lsu_align (combinational), containing:
  - Store lane/byte-enable generation.
  - Load extraction and sign-extension.
  - Misalignment detect.
- mem_lsu keeps the FSM, request latches and output registers.

## Test plan
- ADDU pass-through: wdata_i=0x12345678, wd_i=3, wreg_i=1 -> next cycle valid_o=1, wd_o=3, wdata_o=0x12345678; dreq_o never asserted.
- LB at 0x1003, drdata_i=0x80FFFFFF, dack_i after 3 wait cycles -> daddr_o=0x1000, stallreq_o high 4 cycles, wdata_o=0xFFFFFF80.
- SH at 0x2002, reg2_i=0xAAAA1234 -> dwe_o=1, dbe_o=1100, dwdata_o=0x12341234; result wreg_o=0.
- LW at 0x3001 -> no dreq_o; next cycle valid_o=1, addr_err_o=1, wreg_o=0.
- LH at 0x4000, drdata_i=0x00007FFF, dack_i same cycle dreq_o rises -> wdata_o=0x00007FFF at cycle n+2.
- SW issued, rst asserted in second REQ cycle -> next cycle dreq_o=0, stallreq_o=0, valid_o=0; a following dack_i pulse produces no valid_o.
